// File: rtl/pipe_add_stream_pkg.sv
// Shared constants and stage payload type for the pipelined stream adder.
package pipe_add_stream_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 128;
  localparam int STAGES_DEF = 2;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 8;

  // Sized for the widest legal build; narrower builds leave the upper sum bits at zero.
  typedef struct packed {
    logic [WIDTH_MAX-1:0] sum;
    logic                 carry;
  } stage_pay_t;
endpackage

// File: rtl/pipe_add_core.sv
// Combinational sum/carry; PIPE_ADD_STREAM_SAT_EN selects unsigned saturation.
module pipe_add_core
  import pipe_add_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output stage_pay_t       res_o
);
  logic [WIDTH:0] sum_full;

  assign sum_full = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    res_o       = '0;
    res_o.carry = sum_full[WIDTH];
`ifdef PIPE_ADD_STREAM_SAT_EN
    res_o.sum[WIDTH-1:0] = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    res_o.sum[WIDTH-1:0] = sum_full[WIDTH-1:0];
`endif
  end
endmodule

// File: rtl/pipe_add_stream.sv
// Valid/ready pipelined adder, STAGES deep, with collapsing bubbles.
// PIPE_ADD_STREAM_SAT_EN (optional) saturates the sum on overflow.
module pipe_add_stream
  import pipe_add_stream_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry
);
  localparam int LAST = STAGES - 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("pipe_add_stream: WIDTH out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("pipe_add_stream: STAGES out of range");
  end

  logic [STAGES-1:0]          vld_q, vld_d, adv;
  logic [WIDTH-1:0]           a_q, b_q;
  stage_pay_t [STAGES-1:1]    pay_q;
  stage_pay_t                 core_res;
  logic                       unused_pay;

  pipe_add_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (core_res)
  );

  // Ready chain: a stage moves if the next one is empty or moving too.
  always_comb begin
    adv       = '0;
    adv[LAST] = vld_q[LAST] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
  end

  assign in_ready = ~vld_q[0] | adv[0];

  always_comb begin
    vld_d = vld_q;
    if (in_ready) vld_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++)
      if (~vld_q[k] | adv[k]) vld_d[k] = adv[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      pay_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (in_valid && in_ready) begin
        a_q <= a;
        b_q <= b;
      end
      if (adv[0]) pay_q[1] <= core_res;
      for (int k = 2; k < STAGES; k++)
        if (adv[k-1]) pay_q[k] <= pay_q[k-1];
    end
  end

  assign out_valid  = vld_q[LAST];
  assign c          = pay_q[LAST].sum[WIDTH-1:0];
  assign carry      = pay_q[LAST].carry;
  assign unused_pay = ^pay_q[LAST];
endmodule

// File: tb/tb_pipe_add_stream.sv
// Directed bench: a 2-stage and a 4-stage instance sharing clock and reset.
module tb_pipe_add_stream;
  localparam int W = 32;
`ifdef PIPE_ADD_STREAM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         iv2, ir2, ov2, or2, cy2;
  logic [W-1:0] a2, b2, c2;
  logic         iv4, ir4, ov4, or4, cy4;
  logic [W-1:0] a4, b4, c4;

  int total = 0;
  int bad   = 0;

  pipe_add_stream #(.WIDTH(W), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .c(c2), .carry(cy2)
  );

  pipe_add_stream #(.WIDTH(W), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .c(c4), .carry(cy4)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rst_ov2 got=%b want=0", ov2); end
    total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL rst_ir2 got=%b want=1", ir2); end
    total++; if (c2 !== '0) begin bad++; $display("FAIL rst_c2 got=%h want=0", c2); end
    total++; if (cy2 !== 1'b0) begin bad++; $display("FAIL rst_cy2 got=%b want=0", cy2); end
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL rst_ov4 got=%b want=0", ov4); end
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL rst_ir4 got=%b want=1", ir4); end
    total++; if (c4 !== '0) begin bad++; $display("FAIL rst_c4 got=%h want=0", c4); end
    total++; if (cy4 !== 1'b0) begin bad++; $display("FAIL rst_cy4 got=%b want=0", cy4); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_vectors();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] vc [4];
    logic         vk [4];
    va = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    vb = '{32'd7, 32'd1,         32'h7FFF_FFFF, 32'hFFFF_FFFF};
    vc = '{32'd12, SAT ? 32'hFFFF_FFFF : 32'h0, 32'hFFFF_FFFF,
           SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE};
    vk = '{1'b0, 1'b1, 1'b0, 1'b1};
    or2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv2 = 1'b1; a2 = va[i]; b2 = vb[i];
      @(negedge clk);
      iv2 = 1'b0;
      total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL add%0d_early got=%b want=0", i, ov2); end
      @(negedge clk);
      total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL add%0d_valid got=%b want=1", i, ov2); end
      total++; if (c2 !== vc[i]) begin bad++; $display("FAIL add%0d_c got=%h want=%h", i, c2, vc[i]); end
      total++; if (cy2 !== vk[i]) begin bad++; $display("FAIL add%0d_carry got=%b want=%b", i, cy2, vk[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    or4 = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      total++;
      if (ov4 !== (n >= 4 && n < 14)) begin
        bad++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", n, ov4, (n >= 4 && n < 14));
      end
      if (n >= 4 && n < 14) begin
        e = W'(3 * (n - 4));
        total++; if (c4 !== e) begin bad++; $display("FAIL b2b_c cyc=%0d got=%0d want=%0d", n, c4, e); end
      end
      if (n < 10) begin
        iv4 = 1'b1; a4 = W'(n); b4 = W'(2 * n);
        #1;
        total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=1", n, ir4); end
      end else begin
        iv4 = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp [$];
    logic [W-1:0] e;
    int j   = 0;
    int got = 0;
    or4 = 1'b0;
    // One item, a bubble, then continuous offers: bubbles must collapse.
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      iv4 = (n != 1); a4 = W'(20 + j); b4 = W'(3 * j);
      #1;
      if (iv4 && ir4) begin exp.push_back(W'(20 + 4 * j)); j++; end
    end
    total++; if (j !== 4) begin bad++; $display("FAIL bp_fill_count got=%0d want=4", j); end
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", ir4); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", n, ov4); end
      total++; if (c4 !== 32'd20) begin bad++; $display("FAIL bp_hold_c cyc=%0d got=%0d want=20", n, c4); end
      total++; if (cy4 !== 1'b0) begin bad++; $display("FAIL bp_hold_carry cyc=%0d got=%b want=0", n, cy4); end
      total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL bp_hold_ready cyc=%0d got=%b want=0", n, ir4); end
    end
    @(negedge clk);
    or4 = 1'b1; iv4 = 1'b1; a4 = W'(20 + j); b4 = W'(3 * j);
    #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", ir4); end
    if (iv4 && ir4) begin exp.push_back(W'(20 + 4 * j)); j++; end
    for (int n = 0; n < 12; n++) begin
      if (n > 0) begin @(negedge clk); iv4 = 1'b0; end
      if (ov4) begin
        total++;
        if (exp.size() == 0) begin
          bad++; $display("FAIL bp_extra_out got=%0d want=none", c4);
        end else begin
          e = exp.pop_front();
          if (c4 !== e) begin bad++; $display("FAIL bp_order got=%0d want=%0d", c4, e); end
        end
        got++;
      end
    end
    total++; if (got !== 5) begin bad++; $display("FAIL bp_drain_count got=%0d want=5", got); end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    or4 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      iv4 = 1'b1; a4 = W'(500 + n); b4 = W'(n);
    end
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL mrst_pre_valid got=%b want=1", ov4); end
    total++; if (c4 !== 32'd500) begin bad++; $display("FAIL mrst_pre_c got=%0d want=500", c4); end
    #2 rst = 1'b1;
    #1;
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b want=0", ov4); end
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%b want=1", ir4); end
    total++; if (c4 !== '0) begin bad++; $display("FAIL mrst_c got=%h want=0", c4); end
    total++; if (cy4 !== 1'b0) begin bad++; $display("FAIL mrst_carry got=%b want=0", cy4); end
    @(negedge clk);
    rst = 1'b0;
    or4 = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ov4) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mrst_ghost got=%0d want=0", seen); end
    @(negedge clk);
    iv4 = 1'b1; a4 = 32'd1; b4 = 32'd2;
    for (int n = 1; n < 4; n++) begin
      @(negedge clk);
      iv4 = 1'b0;
      total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL mrst_after_early cyc=%0d got=%b want=0", n, ov4); end
    end
    @(negedge clk);
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL mrst_after_valid got=%b want=1", ov4); end
    total++; if (c4 !== 32'd3) begin bad++; $display("FAIL mrst_after_c got=%0d want=3", c4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0;
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0;
    test_reset();
    test_add_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
